// File: rtl/mac_lane_array.sv
// rtl/mac_lane_array.sv - NLANE-lane signed MAC array with programmable run length
module mac_lane_array #(
    parameter int DW    = 16,
    parameter int NLANE = 8,
    parameter int NMAX  = 64,
    parameter int SHIFT = 8,
    parameter int LW    = $clog2(NMAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [LW-1:0]       cfg_len,
    input  logic                cfg_relu,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NLANE*DW-1:0] data,
    input  logic [NLANE*DW-1:0] weight,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NLANE*DW-1:0] result,
    output logic                busy
);
    localparam int AW = 2 * DW + $clog2(NMAX);
    localparam logic [LW-1:0] LMAX = LW'(NMAX);
    localparam logic [LW-1:0] LONE = LW'(1);
    localparam logic signed [AW:0] SMAX = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW:0] SMIN = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

    logic                w_stall;
    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic                w_relu;
    logic                w_done;
    logic [LW-1:0]       w_len_cfg;
    logic [LW-1:0]       w_len;
    logic [LW-1:0]       r_cnt;
    logic [LW-1:0]       r_len;
    logic                r_relu;
    logic                r_s1_valid;
    logic                r_s1_last;
    logic                r_s1_relu;
    logic                r_out_valid;
    logic [NLANE*DW-1:0] r_result;
    wire  [NLANE*DW-1:0] w_res;

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & ~w_stall;
    assign w_first  = (r_cnt == '0);
    assign w_done   = r_s1_valid & r_s1_last;

    always_comb begin
        w_len_cfg = cfg_len;
        if (cfg_len == '0) begin
            w_len_cfg = LONE;
        end else if (cfg_len > LMAX) begin
            w_len_cfg = LMAX;
        end
    end

    // The first beat of a run uses the live cfg; later beats use the latched copy.
    assign w_len  = w_first ? w_len_cfg : r_len;
    assign w_relu = w_first ? cfg_relu : r_relu;
    assign w_last = (r_cnt == w_len - LONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_relu     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_relu  <= 1'b0;
        end else if (clr) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last <= w_last;
                r_s1_relu <= w_relu;
                r_cnt     <= w_last ? '0 : r_cnt + LONE;
                if (w_first) begin
                    r_len  <= w_len_cfg;
                    r_relu <= cfg_relu;
                end
            end
        end
    end

    // A pending result may still drain during clr; it is never cleared by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_done & ~clr;
            if (w_done && !clr) begin
                r_result <= w_res;
            end
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        logic signed [2*DW-1:0] w_a;
        logic signed [2*DW-1:0] w_b;
        logic signed [2*DW-1:0] r_prod;
        logic signed [AW-1:0]   r_acc;
        logic signed [AW:0]     w_sum;
        logic signed [AW:0]     w_rnd;
        logic        [DW-1:0]   w_sat;

        assign w_a   = {{DW{data[g*DW+DW-1]}}, data[g*DW +: DW]};
        assign w_b   = {{DW{weight[g*DW+DW-1]}}, weight[g*DW +: DW]};
        assign w_sum = {{(AW + 1 - 2*DW){r_prod[2*DW-1]}}, r_prod} + {r_acc[AW-1], r_acc};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_prod <= '0;
                r_acc  <= '0;
            end else if (clr) begin
                r_acc <= '0;
            end else if (!w_stall) begin
                if (w_accept) begin
                    r_prod <= w_a * w_b;
                end
                if (r_s1_valid) begin
                    r_acc <= r_s1_last ? '0 : w_sum[AW-1:0];
                end
            end
        end

        if (SHIFT > 0) begin : g_round
            localparam logic signed [AW:0] RND = (AW + 1)'(1) << (SHIFT - 1);
            assign w_rnd = (w_sum + RND) >>> SHIFT;
        end else begin : g_pass
            assign w_rnd = w_sum;
        end

        assign w_sat = (w_rnd > SMAX) ? SMAX[DW-1:0] :
                       (w_rnd < SMIN) ? SMIN[DW-1:0] : w_rnd[DW-1:0];
        assign w_res[g*DW +: DW] = (r_s1_relu && w_sat[DW-1]) ? '0 : w_sat;
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = (r_cnt != '0) | r_s1_valid;
endmodule

// File: tb/tb_mac_lane_array.sv
// tb/tb_mac_lane_array.sv - randomized self-checking bench for mac_lane_array
module tb_mac_lane_array;
    localparam int DW    = 16;
    localparam int NLANE = 8;
    localparam int NMAX  = 64;
    localparam int LW    = $clog2(NMAX + 1);
    localparam int W     = NLANE * DW;
    localparam longint SATP = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint SATN = -(longint'(1) <<< (DW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          cfg_relu = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [LW-1:0] cfg_len = '0;
    logic [W-1:0]  data = '0;
    logic [W-1:0]  weight = '0;
    logic          in_ready0, in_ready8, out_valid0, out_valid8, busy0, busy8;
    logic [W-1:0]  result0, result8;

    always #5 clk = ~clk;

    mac_lane_array #(.DW(DW), .NLANE(NLANE), .NMAX(NMAX), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready0), .data(data), .weight(weight),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .busy(busy0));

    mac_lane_array #(.DW(DW), .NLANE(NLANE), .NMAX(NMAX), .SHIFT(8)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready8), .data(data), .weight(weight),
        .out_valid(out_valid8), .out_ready(out_ready), .result(result8), .busy(busy8));

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp8_q[$];
    logic [W-1:0] e0, e8;
    longint       m_sum[NLANE];
    int           m_cnt = 0;
    int           m_len = 1;
    bit           m_relu = 1'b0;

    function automatic logic [DW-1:0] lane_res(longint sum, int sh, bit relu);
        longint r;
        r = sum;
        if (sh > 0) r = (sum + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > SATP) r = SATP;
        if (r < SATN) r = SATN;
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] lane(logic [W-1:0] v, int i);
        return v[i*DW +: DW];
    endfunction

    function automatic logic [W-1:0] put(logic [W-1:0] v, int i, int x);
        logic [W-1:0] t;
        t = v;
        t[i*DW +: DW] = DW'(x);
        return t;
    endfunction

    function automatic logic [W-1:0] rand_vec(int mag);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NLANE; i++) v = put(v, i, int'($urandom_range(2 * mag, 0)) - mag);
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < NLANE; i++) m_sum[i] = 0;
    endtask

    task automatic model_beat(input logic [W-1:0] d, input logic [W-1:0] w, input int cl, input bit rl);
        logic [W-1:0] v0, v8;
        if (m_cnt == 0) begin
            m_len  = (cl == 0) ? 1 : ((cl > NMAX) ? NMAX : cl);
            m_relu = rl;
        end
        for (int i = 0; i < NLANE; i++)
            m_sum[i] += longint'($signed(d[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
        m_cnt++;
        if (m_cnt == m_len) begin
            for (int i = 0; i < NLANE; i++) begin
                v0[i*DW +: DW] = lane_res(m_sum[i], 0, m_relu);
                v8[i*DW +: DW] = lane_res(m_sum[i], 8, m_relu);
            end
            exp0_q.push_back(v0);
            exp8_q.push_back(v8);
            model_reset();
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [W-1:0] w, input int cl, input bit rl);
        bit ok;
        ok = 1'b0;
        data = d; weight = w; cfg_len = LW'(cl); cfg_relu = rl; in_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk); #1;
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL send_beat in_ready=0 for 64 cycles, required 1");
        end else begin
            model_beat(d, w, cl, rl);
        end
    endtask

    task automatic wait_drain();
        in_valid = 1'b0;
        for (int k = 0; k < 300 && (exp0_q.size() != 0 || exp8_q.size() != 0); k++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_ready && out_valid0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++; $display("FAIL sb_shift0 got=%h required=no result", result0);
            end else begin
                e0 = exp0_q.pop_front();
                if (result0 !== e0) begin errors++; $display("FAIL sb_shift0 got=%h required=%h", result0, e0); end
            end
        end
        if (!rst && out_ready && out_valid8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                errors++; $display("FAIL sb_shift8 got=%h required=no result", result8);
            end else begin
                e8 = exp8_q.pop_front();
                if (result8 !== e8) begin errors++; $display("FAIL sb_shift8 got=%h required=%h", result8, e8); end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid0 !== 1'b0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b%b required=00", out_valid0, out_valid8); end
        checks++; if (result0 !== '0 || result8 !== '0) begin errors++; $display("FAIL reset_result got=%h required=0", result0 | result8); end
        checks++; if (busy0 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b required=00", busy0, busy8); end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (in_ready0 !== 1'b1 || in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b%b required=11", in_ready0, in_ready8); end
    endtask

    task automatic test_single_run();
        logic [W-1:0] d, w;
        d = {NLANE{16'd3}};
        w = {NLANE{16'd2}};
        for (int b = 0; b < 4; b++) send_beat(d, w, 4, 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_early got=%b required=0", out_valid0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy got=%b required=1", busy0); end
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b1 || out_valid8 !== 1'b1) begin errors++; $display("FAIL single_latency got=%b%b required=11", out_valid0, out_valid8); end
        checks++; if (result0 !== {NLANE{16'd24}}) begin errors++; $display("FAIL single_result got=%h required=%h", result0, {NLANE{16'd24}}); end
        checks++; if (result8 !== '0) begin errors++; $display("FAIL single_result_shift got=%h required=0", result8); end
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL single_pulse out_valid=%b busy=%b required=0 0", out_valid0, busy0); end
        wait_drain();
    endtask

    task automatic test_round_sat();
        logic [W-1:0] da, wa, db, wb;
        da = put(put(put(put('0, 0, 100), 3, 32767), 4, -32768), 7, 1);
        wa = put(put(put(put('0, 0, 300), 3, 32767), 4, 32767), 7, 1);
        db = put(put(put(put('0, 1, -3), 2, 384), 5, -128), 6, -129);
        wb = put(put(put(put('0, 1, 128), 2, 1), 5, 1), 6, 1);
        for (int b = 0; b < NMAX; b++) send_beat(da, wa, NMAX + 5, 1'b0);
        send_beat(db, wb, 0, 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL clamp_len out_valid=%b required=1 after NMAX beats", out_valid0); end
        checks++; if ({lane(result0, 0), lane(result0, 4), lane(result0, 7)} !== {16'd32767, 16'h8000, 16'd64})
            begin errors++; $display("FAIL sat_shift0 got=%h required=%h", {lane(result0, 0), lane(result0, 4), lane(result0, 7)}, {16'd32767, 16'h8000, 16'd64}); end
        checks++; if ({lane(result8, 0), lane(result8, 3), lane(result8, 4)} !== {16'd7500, 16'd32767, 16'h8000})
            begin errors++; $display("FAIL sat_shift8 got=%h required=%h", {lane(result8, 0), lane(result8, 3), lane(result8, 4)}, {16'd7500, 16'd32767, 16'h8000}); end
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL len0_run out_valid=%b required=1", out_valid8); end
        checks++; if ({lane(result8, 1), lane(result8, 2), lane(result8, 5), lane(result8, 6)} !== {16'hFFFF, 16'd2, 16'd0, 16'hFFFF})
            begin errors++; $display("FAIL round got=%h required=%h", {lane(result8, 1), lane(result8, 2), lane(result8, 5), lane(result8, 6)}, {16'hFFFF, 16'd2, 16'd0, 16'hFFFF}); end
        wait_drain();
    endtask

    task automatic test_relu();
        logic [W-1:0] d1, w1, d2, w2;
        d1 = put(put('0, 0, -5), 1, 5);
        w1 = put(put('0, 0, 7), 1, 7);
        d2 = put(put('0, 0, 2), 1, 2);
        w2 = put(put('0, 0, 3), 1, 3);
        send_beat(d1, w1, 2, 1'b1);
        send_beat(d2, w2, 2, 1'b1);
        send_beat(d1, w1, 2, 1'b0);
        checks++; if (out_valid0 !== 1'b1 || {lane(result0, 0), lane(result0, 1)} !== {16'd0, 16'd41})
            begin errors++; $display("FAIL relu_on valid=%b got=%h required=1 %h", out_valid0, {lane(result0, 0), lane(result0, 1)}, {16'd0, 16'd41}); end
        send_beat(d2, w2, 2, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b1 || {lane(result0, 0), lane(result0, 1)} !== {16'hFFE3, 16'd41})
            begin errors++; $display("FAIL relu_off valid=%b got=%h required=1 %h", out_valid0, {lane(result0, 0), lane(result0, 1)}, {16'hFFE3, 16'd41}); end
        wait_drain();
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 1'b0;
        fork
            begin
                for (int b = 0; b < 12; b++) send_beat(rand_vec(200), rand_vec(200), 1, 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(posedge clk); #1;
                    seen = out_valid0;
                end
                if (!seen) begin
                    errors++; checks++; $display("FAIL bp_wait out_valid=0 for 50 cycles, required 1");
                end else begin
                    out_ready = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        checks++; if (in_ready0 !== 1'b0 || in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b%b required=00", in_ready0, in_ready8); end
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            end
        join
        wait_drain();
        checks++; if (exp0_q.size() != 0 || exp8_q.size() != 0) begin errors++; $display("FAIL bp_drain left=%0d required=0", exp0_q.size()); end
    endtask

    task automatic test_len_change();
        send_beat(rand_vec(300), rand_vec(300), 3, 1'b0);
        send_beat(rand_vec(300), rand_vec(300), 5, 1'b1);
        send_beat(rand_vec(300), rand_vec(300), 5, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL len_change out_valid=%b required=1", out_valid0); end
        send_beat(rand_vec(300), rand_vec(300), 2, 1'b1);
        send_beat(rand_vec(300), rand_vec(300), 7, 1'b0);
        wait_drain();
    endtask

    task automatic test_clr();
        send_beat(rand_vec(1000), rand_vec(1000), 4, 1'b0);
        send_beat(rand_vec(1000), rand_vec(1000), 4, 1'b0);
        data = rand_vec(1000); in_valid = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        model_reset();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b required=0", busy0); end
        for (int b = 0; b < 4; b++) send_beat({NLANE{16'd1}}, {NLANE{16'd1}}, 4, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b1 || result0 !== {NLANE{16'd4}}) begin errors++; $display("FAIL clr_fresh valid=%b got=%h required=1 %h", out_valid0, result0, {NLANE{16'd4}}); end
        wait_drain();
    endtask

    task automatic test_rst_midrun();
        out_ready = 1'b0;
        send_beat(rand_vec(500), rand_vec(500), 2, 1'b0);
        send_beat(rand_vec(500), rand_vec(500), 2, 1'b0);
        send_beat(rand_vec(500), rand_vec(500), 4, 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid0 !== 1'b1 || result0 !== exp0_q[0] || result8 !== exp8_q[0])
            begin errors++; $display("FAIL rst_pending valid=%b got=%h required=1 %h", out_valid0, result0, exp0_q[0]); end
        void'(exp0_q.pop_front());
        void'(exp8_q.pop_front());
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b0 || out_valid8 !== 1'b0 || busy0 !== 1'b0 || busy8 !== 1'b0)
            begin errors++; $display("FAIL rst_mid valid=%b%b busy=%b%b required=00 00", out_valid0, out_valid8, busy0, busy8); end
        checks++; if (result0 !== '0 || result8 !== '0) begin errors++; $display("FAIL rst_mid_result got=%h required=0", result0 | result8); end
        rst = 1'b0; out_ready = 1'b1;
        model_reset();
        send_beat(rand_vec(500), rand_vec(500), 1, 1'b0);
        wait_drain();
        checks++; if (exp0_q.size() != 0) begin errors++; $display("FAIL rst_drain left=%0d required=0", exp0_q.size()); end
    endtask

    task automatic test_random();
        bit drv_done;
        drv_done = 1'b0;
        fork
            begin
                for (int r = 0; r < 40; r++) begin
                    int len, mag;
                    bit rl;
                    len = int'($urandom_range(6, 1));
                    rl  = 1'($urandom_range(1, 0));
                    case ($urandom_range(2, 0))
                        0: mag = 3;
                        1: mag = 200;
                        default: mag = 32767;
                    endcase
                    for (int b = 0; b < len; b++) begin
                        send_beat(rand_vec(mag), rand_vec(mag),
                                  (b == 0) ? len : int'($urandom_range(NMAX + 5, 0)), rl);
                        if ($urandom_range(3, 0) == 0) begin
                            in_valid = 1'b0;
                            @(posedge clk); #1;
                        end
                    end
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(3, 0) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++; if (exp0_q.size() != 0 || exp8_q.size() != 0) begin errors++; $display("FAIL random_drain left=%0d required=0", exp0_q.size()); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_single_run();
        test_round_sat();
        test_relu();
        test_backpressure();
        test_len_change();
        test_clr();
        test_rst_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
